// File: rtl/loader_pkg.sv
// Shared state encoding and framing constants for the flash loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam int unsigned LEN_BYTES = 2;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
module byte_packer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_full_o
);
    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WIDTH-1:0] word_q;
    logic [IDX_W-1:0] idx_q;

    // word_o already includes the byte being loaded so the word can be captured on the same edge
    always_comb begin
        word_o = word_q;
        if (load_i) begin
            word_o[{idx_q, 3'b000} +: 8] = byte_i;
        end
    end

    assign word_full_o = load_i && (idx_q == IDX_W'(BYTES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_o;
            idx_q  <= word_full_o ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/flash_loader.sv
// Streams a length-prefixed byte image into the RAM flash port, holding busy during the load.
module flash_loader
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              flash_en,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [WIDTH-1:0]  flash_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = 8 * LEN_BYTES;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   to_q;
    logic [ADDR_W:0]   ww_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  data_q;
    logic              in_ready_q, flash_en_q, busy_q, done_q, error_q;

    logic              accept, restart, to_expired, len_bad, last_word;
    logic [CNT_W-1:0]  len_new;
    logic [WIDTH-1:0]  pk_word;
    logic              pk_full;

    assign accept     = in_valid && in_ready_q;
    assign restart    = start && (state_q inside {IDLE, DONE, ERROR});
    assign to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign len_new    = {in_data, cnt_q[7:0]};
    assign len_bad    = (len_new == '0) || (32'(len_new) > MAX_WORDS);
    assign last_word  = (32'(ww_q) + 32'd1) == 32'(cnt_q);

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (restart),
        .load_i      (accept && (state_q == DATA)),
        .byte_i      (in_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = LEN0;
            LEN0:  if (accept) state_d = LEN1;
            LEN1: begin
                if (accept)          state_d = len_bad ? ERROR : DATA;
                else if (to_expired) state_d = ERROR;
            end
            DATA: begin
                if (accept) begin
                    if (pk_full) state_d = WRITE;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            WRITE:   state_d = last_word ? DONE : DATA;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from state_d so each flag is valid in the same cycle as its state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            to_q       <= '0;
            ww_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
            flash_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d inside {LEN0, LEN1, DATA};
            busy_q     <= state_d inside {LEN0, LEN1, DATA, WRITE};
            flash_en_q <= (state_d == WRITE);
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERROR);

            if (accept && state_q == LEN0) cnt_q[7:0]  <= in_data;
            if (accept && state_q == LEN1) cnt_q[15:8] <= in_data;

            if ((state_q inside {LEN1, DATA}) && (state_d == state_q) && !accept) begin
                to_q <= to_q + 1'b1;
            end else begin
                to_q <= '0;
            end

            if (restart) begin
                ww_q   <= '0;
                addr_q <= '0;
            end else if (state_q == DATA && state_d == WRITE) begin
                addr_q <= ww_q[ADDR_W-1:0];
                data_q <= pk_word;
            end else if (state_q == WRITE) begin
                ww_q <= ww_q + 1'b1;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign flash_en      = flash_en_q;
    assign flash_addr    = addr_q;
    assign flash_data    = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with a write scoreboard fed by the stimulus.
module tb_flash_loader;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TOC    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, flash_en, busy, done, error;
    logic [ADDR_W-1:0] flash_addr;
    logic [WIDTH-1:0]  flash_data;
    logic [ADDR_W:0]   words_written;

    int n_cmp = 0;
    int n_err = 0;
    int writes_seen = 0;
    int ws;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    flash_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TOC)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flash_en      (flash_en),
        .flash_addr    (flash_addr),
        .flash_data    (flash_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (flash_en === 1'b1) begin
            writes_seen++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", flash_addr, flash_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(flash_addr), 64'(e.a));
                chk("write_data", 64'(flash_data), 64'(e.d));
                chk("write_in_ready", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n = 0;
        int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(n < 50), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
    endtask

    task automatic wait_end();
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("end_wait", 64'(n < 40), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_flash_en", 64'(flash_en), 0);
        chk("rst_flash_addr", 64'(flash_addr), 0);
        chk("rst_flash_data", 64'(flash_data), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_words", 64'(words_written), 0);
        rst = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 0);

        // Normal two-word load, no gaps
        ws = writes_seen;
        pulse_start();
        chk("len0_ready", 64'(in_ready), 1);
        chk("len0_busy", 64'(busy), 1);
        exp_q.push_back(wr_t'{a: 4'd0, d: 32'hDEADBEEF});
        exp_q.push_back(wr_t'{a: 4'd1, d: 32'h12345678});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEADBEEF, 0);
        chk("w0_latency_en", 64'(flash_en), 1);
        chk("w0_in_ready", 64'(in_ready), 0);
        send_word(32'h12345678, 0);
        chk("w1_latency_en", 64'(flash_en), 1);
        chk("w1_busy", 64'(busy), 1);
        tick();
        chk("normal_busy_fall", 64'(busy), 0);
        chk("normal_done", 64'(done), 1);
        chk("normal_words", 64'(words_written), 2);
        chk("normal_en_low", 64'(flash_en), 0);
        chk("normal_writes", 64'(writes_seen - ws), 2);

        // Bad lengths: zero, above capacity, and one past capacity
        ws = writes_seen;
        pulse_start();
        chk("restart_done_clr", 64'(done), 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("len0_error", 64'(error), 1);
        chk("len0_busy", 64'(busy), 0);
        chk("len0_in_ready", 64'(in_ready), 0);
        pulse_start();
        chk("restart_err_clr", 64'(error), 0);
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        chk("len2049_error", 64'(error), 1);
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        chk("len17_error", 64'(error), 1);
        chk("badlen_writes", 64'(writes_seen - ws), 0);
        pulse_start();
        exp_q.push_back(wr_t'{a: 4'd0, d: 32'h11223344});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        tick();
        chk("recover_done", 64'(done), 1);
        chk("recover_words", 64'(words_written), 1);

        // Timeout after three data bytes
        ws = writes_seen;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        repeat (TOC - 1) tick();
        chk("to_pre_error", 64'(error), 0);
        chk("to_pre_busy", 64'(busy), 1);
        tick();
        chk("to_error", 64'(error), 1);
        chk("to_busy", 64'(busy), 0);
        chk("to_words", 64'(words_written), 0);
        chk("to_writes", 64'(writes_seen - ws), 0);
        pulse_start();
        exp_q.push_back(wr_t'{a: 4'd0, d: 32'hA50F0F3C});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h0F, 0);
        send_byte(8'h0F, 0);
        repeat (TOC - 1) tick();
        send_byte(8'hA5, 0);
        tick();
        chk("to_edge_error", 64'(error), 0);
        chk("to_edge_done", 64'(done), 1);

        // Gapped stream with a start pulse mid-load
        ws = writes_seen;
        pulse_start();
        exp_q.push_back(wr_t'{a: 4'd0, d: 32'hDEADBEEF});
        exp_q.push_back(wr_t'{a: 4'd1, d: 32'h12345678});
        send_byte(8'h02, 3);
        send_byte(8'h00, 3);
        send_word(32'hDEADBEEF, 5);
        pulse_start();
        chk("midstart_busy", 64'(busy), 1);
        chk("midstart_words", 64'(words_written), 1);
        send_word(32'h12345678, 5);
        wait_end();
        chk("gap_done", 64'(done), 1);
        chk("gap_words", 64'(words_written), 2);
        chk("gap_writes", 64'(writes_seen - ws), 2);

        // Reset on the write cycle
        ws = writes_seen;
        pulse_start();
        exp_q.push_back(wr_t'{a: 4'd0, d: 32'hCAFEF00D});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        chk("rstw_en", 64'(flash_en), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstw_en_clr", 64'(flash_en), 0);
        chk("rstw_addr_clr", 64'(flash_addr), 0);
        chk("rstw_data_clr", 64'(flash_data), 0);
        chk("rstw_busy_clr", 64'(busy), 0);
        chk("rstw_words_clr", 64'(words_written), 0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw_no_ready", 64'(in_ready), 0);
            chk("rstw_no_count", 64'(words_written), 0);
        end
        in_valid = 1'b0;
        chk("rstw_writes", 64'(writes_seen - ws), 1);

        // Full capacity, data word equals address
        ws = writes_seen;
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(wr_t'{a: ADDR_W'(i), d: 32'(i)});
            send_word(32'(i), 0);
        end
        tick();
        chk("full_done", 64'(done), 1);
        chk("full_error", 64'(error), 0);
        chk("full_words", 64'(words_written), 16);
        chk("full_last_addr", 64'(flash_addr), 15);
        chk("full_writes", 64'(writes_seen - ws), 16);
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Initiator side of the RAM flash port (flash_en / flash_addr / flash_data).
- Receives a byte stream with a valid/ready handshake, typically from the UART receiver.
- Parses a 16-bit word count, packs bytes little-endian into WIDTH-bit words and writes them to consecutive word addresses starting at 0.
- busy is used to hold the CPU in reset while the program image loads.

Parameters:
- WIDTH, 32, data word width; must be a multiple of 8; BYTES = WIDTH/8.
- ADDR_W, 11, flash word-address width; capacity = 2**ADDR_W words.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes once a load has begun.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin load; honoured in IDLE, DONE, ERROR; ignored otherwise
- in_data  in  8  stream byte
- in_valid  in  1  byte present
- in_ready  out  1  loader accepts byte
- flash_en  out  1  single-cycle write strobe to RAM flash port
- flash_addr  out  ADDR_W  word address
- flash_data  out  WIDTH  word to write
- busy  out  1  high in LEN0, LEN1, DATA, WRITE
- done  out  1  sticky; load completed
- error  out  1  sticky; bad length or timeout
- words_written  out  ADDR_W+1  count of words strobed this load

Behaviour:
- Reset (rst==0 at posedge): state IDLE. flash_en=0, flash_addr=0, flash_data=0, in_ready=0, busy=0, done=0, error=0, words_written=0. Takes effect on the same edge even mid-load. A partial load is abandoned and is not resumed.
- Handshake: a byte is accepted on a posedge with in_valid && in_ready. in_ready is a function of state only (high in LEN0, LEN1, DATA) and never depends on in_valid.
- IDLE: on start -> LEN0. Clear done, error, words_written, flash_addr, byte index, timeout counter.
- LEN0: accept byte into count[7:0] -> LEN1. No timeout in LEN0.
- LEN1: accept byte into count[15:8].
  - count==0 or count > 2**ADDR_W -> ERROR.
  - Otherwise -> DATA.
- DATA: accepted byte k (0..BYTES-1) is placed in word bits [8k+7:8k]. On acceptance of byte BYTES-1 -> WRITE; byte index wraps to 0.
- WRITE (exactly 1 cycle, in_ready=0):
  - flash_en=1, flash_addr = words_written[ADDR_W-1:0], flash_data = assembled word.
  - Next edge: words_written += 1.
  - If new words_written == count -> DONE, else -> DATA.
  - Latency: flash_en is high in the cycle after the last byte of the word is accepted.
- flash_en is 0 in every state except WRITE. flash_addr and flash_data hold their last values outside WRITE.
- DONE: done=1, busy=0. start restarts (-> LEN0, flags cleared). Input bytes are not consumed.
- ERROR: error=1, busy=0, no further writes; a partially packed word is discarded. start restarts.
- Timeout: counter clears on every accepted byte and on entry to LEN1 or DATA. It increments each cycle in LEN1 and DATA without acceptance. Reaching TIMEOUT_CYCLES -> ERROR.
- Simultaneous events:
  - start while busy: ignored.
  - Acceptance and timeout in the same cycle: acceptance wins.
  - start and rst both asserted: rst wins.
- Maximum load: count = 2**ADDR_W. The last write goes to address 2**ADDR_W-1 and words_written ends at 2**ADDR_W (hence ADDR_W+1 bits). No address wrap occurs.
- Arithmetic: count is 16 bits, compared zero-extended against words_written.

Decomposition:
- Shared package loader_pkg:
  - loader_state_t enum {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR}
  - LEN_BYTES=2 constant
- Sub-module byte_packer (WIDTH): shift/insert register with byte index; outputs the word and a word_full flag; clear input. The FSM, timeout counter and address counter stay in flash_loader.

Test Plan:
- Normal load: start; bytes 02 00, EF BE AD DE, 78 56 34 12 with in_valid held high -> flash_en pulses twice: addr 0 data DEADBEEF, addr 1 data 12345678. done=1, words_written=2, busy falls the cycle after the second write, in_ready=0 during each WRITE.
- Bad length: counts 00 00 and 01 08 (2049) -> error=1 after the second length byte, no flash_en, busy=0. A following start then count 01 00 plus one word succeeds.
- Timeout (TIMEOUT_CYCLES=16): start, count 01 00, 3 data bytes, then idle 16 cycles -> error=1, no flash_en, words_written=0. Idle of 15 cycles then the 4th byte -> normal write.
- Back-pressure and gaps: random in_valid gaps below the timeout; start pulsed mid-load -> identical writes to the gap-free run; start ignored.
- Reset mid-load: rst low on the cycle flash_en is high -> that write completes on that edge. Outputs read zero the next cycle, state IDLE, and subsequent bytes are not accepted (in_ready=0).
- Full capacity: count 2**ADDR_W, with data word = address -> last write at address 2**ADDR_W-1, words_written = 2**ADDR_W, done=1, flash_addr never wraps.
